// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV64 load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_WAIT0,
    S_BEAT1,
    S_WAIT1,
    S_RESP
  } state_e;

  function automatic logic [3:0] access_size(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

  // Byte lanes touched across two consecutive 8-byte words.
  function automatic logic [15:0] lane_mask(input logic [2:0] f3, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << access_size(f3)) - 16'd1;
    return m << off;
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    return (f3 == F3_BAD) || (we && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store data/mask positioning across two beats,
// load extraction from the {hi,lo} word pair with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] lo_i,
  input  logic [63:0] hi_i,
  output logic [63:0] wdata0_o,
  output logic [63:0] wdata1_o,
  output logic [7:0]  wmask0_o,
  output logic [7:0]  wmask1_o,
  output logic        split_o,
  output logic [63:0] rdata_o
);

  logic [5:0]   sh;
  logic [127:0] wide_w;
  logic [15:0]  m;
  logic [63:0]  raw;

  assign sh       = {off_i, 3'b000};
  assign wide_w   = {64'd0, wdata_i} << sh;
  assign wdata0_o = wide_w[63:0];
  assign wdata1_o = wide_w[127:64];
  assign m        = lane_mask(funct3_i, off_i);
  assign wmask0_o = m[7:0];
  assign wmask1_o = m[15:8];
  assign split_o  = ({1'b0, off_i} + access_size(funct3_i)) > 4'd8;
  assign raw      = 64'({hi_i, lo_i} >> sh);

  always_comb begin
    rdata_o = raw;
    case (funct3_i)
      F3_B:    rdata_o = {{56{raw[7]}}, raw[7:0]};
      F3_BU:   rdata_o = {56'd0, raw[7:0]};
      F3_H:    rdata_o = {{48{raw[15]}}, raw[15:0]};
      F3_HU:   rdata_o = {48'd0, raw[15:0]};
      F3_W:    rdata_o = {{32{raw[31]}}, raw[31:0]};
      F3_WU:   rdata_o = {32'd0, raw[31:0]};
      F3_D:    rdata_o = raw;
      default: rdata_o = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV64 load/store unit: one request at a time, split into at most two aligned
// memory beats, single-cycle response pulse with extended load data.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  state_e      state_q;
  logic [63:0] addr_q, wdata_q, lo_q, hi_q;
  logic [2:0]  f3_q;
  logic        we_q;

  logic        idle;
  logic [2:0]  a_f3, a_off;
  logic [63:0] a_wdata, a_lo, a_hi;
  logic [63:0] wd0, wd1, rdata_ext, beat1_addr;
  logic [7:0]  wm0, wm1;
  logic        split;

  // In IDLE the aligner looks at the incoming request so beat0 can be
  // registered on the accept edge; afterwards it works from held state.
  assign idle       = (state_q == S_IDLE);
  assign a_f3       = idle ? req_funct3    : f3_q;
  assign a_off      = idle ? req_addr[2:0] : addr_q[2:0];
  assign a_wdata    = idle ? req_wdata     : wdata_q;
  assign a_lo       = (state_q == S_WAIT0) ? mem_rdata : lo_q;
  assign a_hi       = (state_q == S_WAIT1) ? mem_rdata : hi_q;
  assign beat1_addr = {addr_q[63:3], 3'b000} + 64'd8;

  lsu_align u_align (
    .funct3_i (a_f3),
    .off_i    (a_off),
    .wdata_i  (a_wdata),
    .lo_i     (a_lo),
    .hi_i     (a_hi),
    .wdata0_o (wd0),
    .wdata1_o (wd1),
    .wmask0_o (wm0),
    .wmask1_o (wm1),
    .split_o  (split),
    .rdata_o  (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      req_ready  <= 1'b1;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            f3_q      <= req_funct3;
            we_q      <= req_we;
            hi_q      <= '0;
            req_ready <= 1'b0;
            if (is_illegal(req_we, req_funct3)) begin
              state_q    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state_q   <= S_BEAT0;
              mem_valid <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[63:3], 3'b000};
              mem_wdata <= req_we ? wd0 : 64'd0;
              mem_wmask <= req_we ? wm0 : 8'd0;
            end
          end
        end
        S_BEAT0: begin
          if (mem_ready) begin
            if (!we_q) begin
              mem_valid <= 1'b0;
              state_q   <= S_WAIT0;
            end else if (split) begin
              state_q   <= S_BEAT1;
              mem_addr  <= beat1_addr;
              mem_wdata <= wd1;
              mem_wmask <= wm1;
            end else begin
              mem_valid  <= 1'b0;
              state_q    <= S_RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        S_WAIT0: begin
          if (mem_rvalid) begin
            lo_q <= mem_rdata;
            if (split) begin
              state_q   <= S_BEAT1;
              mem_valid <= 1'b1;
              mem_addr  <= beat1_addr;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end else begin
              state_q    <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_ext;
            end
          end
        end
        S_BEAT1: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (we_q) begin
              state_q    <= S_RESP;
              resp_valid <= 1'b1;
            end else begin
              state_q <= S_WAIT1;
            end
          end
        end
        S_WAIT1: begin
          if (mem_rvalid) begin
            hi_q       <= mem_rdata;
            state_q    <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_ext;
          end
        end
        S_RESP: begin
          state_q   <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state_q   <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the single-cycle RV64 core datapath. It accepts one load or store request at a time (address from the ALU, store data from rs2, funct3 from the instruction) and drives a 64-bit, 8-byte-aligned data-memory port with byte write masks. Accesses that cross an 8-byte boundary are split into two memory beats. Load data is returned as a single result, shifted and sign/zero-extended to 64 bits, ready for register writeback.

## Interface
Parameters:
- none; widths fixed to RV64 (64-bit address/data, 8-byte memory word).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- req_addr  in  64  byte address
- req_wdata  in  64  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data (0 for stores/errors)
- resp_err  out  1  illegal funct3, qualified by resp_valid
- mem_valid  out  1  memory beat request
- mem_ready  in  1  memory accepts beat
- mem_we  out  1  beat is a write
- mem_addr  out  64  beat address, bits [2:0] always 0
- mem_wdata  out  64  write data, byte-lane positioned
- mem_wmask  out  8  byte enables, bit i = lane i
- mem_rvalid  in  1  read data valid
- mem_rdata  in  64  read data

## Operation
- Request latched on req_valid & req_ready; addr, we, funct3, wdata held in registers for the whole transaction.
- Size = 1 << funct3[1:0]; off = addr[2:0]. Illegal: funct3 = 111, or store with funct3[2] = 1.
- split = (off + size > 8).
- 16-bit lane mask m = ((1<<size)-1) << off; beat0 mask = m[7:0], beat1 mask = m[15:8].
- 128-bit write data = wdata << (8*off); beat0 gets [63:0], beat1 gets [127:64].
- beat0 addr = addr & ~7; beat1 addr = beat0 addr + 8, wrapping mod 2^64.
- Loads: beat0 rdata captured to lo, beat1 to hi (hi = 0 if not split); result = ({hi,lo} >> 8*off) truncated to size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
- FSM states: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
  - IDLE: req_ready=1. On accept: illegal → RESP with err; else → BEAT0.
  - BEATn: mem_valid=1, outputs stable until mem_ready. On mem_ready: store → (split & n=0 ? BEAT1 : RESP); load → WAITn.
  - WAITn: on mem_rvalid capture rdata; → (split & n=0 ? BEAT1 : RESP).
  - RESP: resp_valid=1 for exactly one cycle, → IDLE.
- No backpressure on response; core must consume the pulse.
- mem_rvalid outside WAIT states ignored.

## Timing
- Reset values: req_ready=1 after reset cycle (state IDLE), mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, resp_valid=0, resp_rdata=0, resp_err=0.
- rst mid-transaction: next edge forces IDLE; mem_valid drops; no resp_valid generated for the aborted request.
- Accept at edge T → mem_valid from T+1. Aligned store, mem_ready=1: resp_valid at T+2. Aligned load, mem_ready=1, mem_rvalid one cycle after handshake: resp_valid at T+3.
- Split adds one BEAT(+WAIT) per extra beat: split store resp at T+3; split load resp at T+5 under same memory timing.
- Illegal request: resp_valid with resp_err=1 at T+1, no mem_valid.
- Back-to-back: next request accepted the cycle after RESP (req_ready high in IDLE).

## Structure
- Shared package: funct3 encoding constants, FSM state enum, size/mask helper function.
- Natural sub-module: lsu_align (combinational shift/mask/extend: store lane positioning and load extraction/extension), instantiated once; FSM and registers in lsu.

## Test plan
- Aligned SD addr 0x80001000 data 0x1122334455667788 → one beat, mem_addr 0x80001000, wmask 0xFF, resp at T+2.
- SH addr 0x80001003 data 0xABCD → wmask 0x18, mem_wdata 0x000000ABCD000000.
- LW addr 0x80001006, memory words 0x00000000_0000FFFF_..._8765xxxx such that bytes 6..9 = 0x01,0x02,0x83,0x84 → two beats (0x80001000, 0x80001008), resp_rdata 0xFFFFFFFF84830201; LWU same → 0x0000000084830201.
- SD addr 0x80001005 → beat0 wmask 0xE0, beat1 wmask 0x1F at 0x80001008; mem_ready held low 3 cycles on beat0 → mem_addr/wdata/wmask stable.
- funct3=111 load → no mem_valid, resp_valid T+1, resp_err=1, rdata 0.
- rst asserted in WAIT0 → IDLE next cycle, no resp_valid, subsequent LB addr 0x80001007 (byte 0x80) → 0xFFFFFFFFFFFFFF80.
